jogo_sequencia_rodadas: RTL and testbench

Parametrised successor of the sequence-memory game top level. The player is shown a growing sequence of button lights and must repeat it. Each round adds one element, up to MAX_RODADAS. The block owns the control FSM, LED playback, press detection, the per-press timeout and the round/address counters. The sequence itself comes from an external combinational-read ROM (`mem_endereco`/`mem_dado`). Seven-segment decoding stays outside, in the board wrapper.

---
 rtl/jogo_pkg.sv | 46 ++++
 rtl/contador_m.sv | 34 +++
 rtl/jogo_sequencia_rodadas.sv | 187 ++++++++++++++++++
 tb/tb_jogo_sequencia_rodadas.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game: FSM state codes and
// the width helpers used to size the counters.
package jogo_pkg;

  localparam logic [3:0] COD_INICIAL     = 4'h0;
  localparam logic [3:0] COD_PREPARA     = 4'h1;
  localparam logic [3:0] COD_MOSTRA      = 4'h2;
  localparam logic [3:0] COD_INTERVALO   = 4'h3;
  localparam logic [3:0] COD_ESPERA      = 4'h4;
  localparam logic [3:0] COD_REGISTRA    = 4'h5;
  localparam logic [3:0] COD_COMPARA     = 4'h6;
  localparam logic [3:0] COD_PROXIMA     = 4'h7;
  localparam logic [3:0] COD_FIM_GANHOU  = 4'hA;
  localparam logic [3:0] COD_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] COD_FIM_PERDEU  = 4'hE;

  typedef enum logic [3:0] {
    INICIAL     = COD_INICIAL,
    PREPARA     = COD_PREPARA,
    MOSTRA      = COD_MOSTRA,
    INTERVALO   = COD_INTERVALO,
    ESPERA      = COD_ESPERA,
    REGISTRA    = COD_REGISTRA,
    COMPARA     = COD_COMPARA,
    PROXIMA     = COD_PROXIMA,
    FIM_GANHOU  = COD_FIM_GANHOU,
    FIM_TIMEOUT = COD_FIM_TIMEOUT,
    FIM_PERDEU  = COD_FIM_PERDEU
  } estado_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int valor);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < valor) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the last count.
module contador_m
  import jogo_pkg::*;
#(
  parameter int M = 16,
  parameter int W = clog2(M)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] Q,
  output logic         fim
);

  logic [W-1:0] r_q;

  // clear has priority over counting
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q <= '0;
    end else if (zera) begin
      r_q <= '0;
    end else if (conta) begin
      r_q <= (r_q == W'(M - 1)) ? '0 : r_q + W'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign Q   = r_q;
  assign fim = (r_q == W'(M - 1));

endmodule

// File: rtl/jogo_sequencia_rodadas.sv
// Sequence-memory game top: control FSM, LED playback, press detection,
// per-press timeout and round/address counters around an external ROM.
module jogo_sequencia_rodadas
  import jogo_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int MAX_RODADAS    = 16,
  parameter int LED_CICLOS     = 500,
  parameter int TIMEOUT_CICLOS = 3000,
  parameter int AW             = clog2(MAX_RODADAS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [AW-1:0]       mem_endereco,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                db_timeout,
  output logic [AW-1:0]       db_rodada,
  output logic [N_BOTOES-1:0] db_jogada,
  output logic [3:0]          db_estado
);

  localparam int TM = max_int(LED_CICLOS, TIMEOUT_CICLOS);
  localparam int TW = clog2(TM);
  localparam logic [TW-1:0] LED_FIM = TW'(LED_CICLOS - 1);
  localparam logic [TW-1:0] TO_FIM  = TW'(TIMEOUT_CICLOS - 1);

  estado_t r_estado, w_prox;

  logic [TW-1:0]       w_timer;
  logic [AW-1:0]       w_endereco, w_rodada;
  logic                w_rodada_fim, w_unused_fim_t, w_unused_fim_e;
  logic                w_zera_t, w_conta_t, w_zera_e, w_conta_e, w_zera_r, w_conta_r;
  logic                w_limpa_jogada, w_registra, w_jogada_feita;
  logic                r_botoes_d;
  logic [N_BOTOES-1:0] r_captura, r_jogada;

  contador_m #(.M(TM), .W(TW)) u_timer (
    .clock(clock), .reset(reset), .zera(w_zera_t), .conta(w_conta_t),
    .Q(w_timer), .fim(w_unused_fim_t)
  );

  contador_m #(.M(MAX_RODADAS), .W(AW)) u_endereco (
    .clock(clock), .reset(reset), .zera(w_zera_e), .conta(w_conta_e),
    .Q(w_endereco), .fim(w_unused_fim_e)
  );

  contador_m #(.M(MAX_RODADAS), .W(AW)) u_rodada (
    .clock(clock), .reset(reset), .zera(w_zera_r), .conta(w_conta_r),
    .Q(w_rodada), .fim(w_rodada_fim)
  );

  // A press only counts on a 0 -> nonzero transition of the button bus.
  assign w_jogada_feita = (|botoes) & ~r_botoes_d;

  // state register
  always_ff @(posedge clock) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_prox;
  end

  // press edge detector and capture of the buttons on the accepted edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_botoes_d <= 1'b0;
      r_captura  <= '0;
    end else begin
      r_botoes_d <= |botoes;
      if (r_estado == ESPERA && w_jogada_feita) r_captura <= botoes;
      else                                      r_captura <= r_captura;
    end
  end

  // last registered press
  always_ff @(posedge clock) begin
    if (!reset)              r_jogada <= '0;
    else if (w_limpa_jogada) r_jogada <= '0;
    else if (w_registra)     r_jogada <= r_captura;
    else                     r_jogada <= r_jogada;
  end

  // next-state and counter control
  always_comb begin
    w_prox         = r_estado;
    w_zera_t       = 1'b0;
    w_conta_t      = 1'b0;
    w_zera_e       = 1'b0;
    w_conta_e      = 1'b0;
    w_zera_r       = 1'b0;
    w_conta_r      = 1'b0;
    w_limpa_jogada = 1'b0;
    w_registra     = 1'b0;
    case (r_estado)
      INICIAL: begin
        if (jogar) w_prox = PREPARA;
        else       w_prox = INICIAL;
      end
      PREPARA: begin
        w_zera_t       = 1'b1;
        w_zera_e       = 1'b1;
        w_zera_r       = 1'b1;
        w_limpa_jogada = 1'b1;
        w_prox         = MOSTRA;
      end
      MOSTRA: begin
        w_conta_t = 1'b1;
        if (w_timer == LED_FIM) begin
          w_zera_t = 1'b1;
          w_prox   = INTERVALO;
        end else begin
          w_prox = MOSTRA;
        end
      end
      INTERVALO: begin
        w_conta_t = 1'b1;
        if (w_timer == LED_FIM) begin
          w_zera_t = 1'b1;
          if (w_endereco == w_rodada) begin
            w_zera_e = 1'b1;
            w_prox   = ESPERA;
          end else begin
            w_conta_e = 1'b1;
            w_prox    = MOSTRA;
          end
        end else begin
          w_prox = INTERVALO;
        end
      end
      ESPERA: begin
        w_conta_t = 1'b1;
        if (w_jogada_feita)          w_prox = REGISTRA;
        else if (w_timer == TO_FIM)  w_prox = FIM_TIMEOUT;
        else                         w_prox = ESPERA;
      end
      REGISTRA: begin
        w_registra = 1'b1;
        w_prox     = COMPARA;
      end
      COMPARA: begin
        if (r_jogada != mem_dado) begin
          w_prox = FIM_PERDEU;
        end else if (w_endereco == w_rodada) begin
          w_prox = PROXIMA;
        end else begin
          w_conta_e = 1'b1;
          w_zera_t  = 1'b1;
          w_prox    = ESPERA;
        end
      end
      PROXIMA: begin
        if (w_rodada_fim) begin
          w_prox = FIM_GANHOU;
        end else begin
          w_conta_r = 1'b1;
          w_zera_e  = 1'b1;
          w_zera_t  = 1'b1;
          w_prox    = MOSTRA;
        end
      end
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
        if (jogar) w_prox = PREPARA;
        else       w_prox = r_estado;
      end
      default: begin
        w_prox = INICIAL;
      end
    endcase
  end

  // Moore status decode
  assign leds         = (r_estado == MOSTRA) ? mem_dado : '0;
  assign pronto       = (r_estado == FIM_GANHOU) || (r_estado == FIM_PERDEU) ||
                        (r_estado == FIM_TIMEOUT);
  assign ganhou       = (r_estado == FIM_GANHOU);
  assign perdeu       = (r_estado == FIM_PERDEU) || (r_estado == FIM_TIMEOUT);
  assign db_timeout   = (r_estado == FIM_TIMEOUT);
  assign db_estado    = r_estado;
  assign db_rodada    = w_rodada;
  assign db_jogada    = r_jogada;
  assign mem_endereco = w_endereco;

endmodule

// File: tb/tb_jogo_sequencia_rodadas.sv
// Randomised game-level bench: each game is scripted round by round and the
// expected per-cycle outputs follow from the playback/press/timeout rules.
module tb_jogo_sequencia_rodadas;

  localparam int NB = 4;
  localparam int MR = 4;
  localparam int LC = 4;
  localparam int TC = 20;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jogar = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] mem_dado;
  logic [AW-1:0] mem_endereco;
  logic [NB-1:0] leds, db_jogada;
  logic          pronto, ganhou, perdeu, db_timeout;
  logic [AW-1:0] db_rodada;
  logic [3:0]    db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  logic [3:0] e_est  = 4'h0;
  logic [3:0] e_leds = 4'h0;
  logic [3:0] e_jog  = 4'h0;
  int         e_rod  = 0;
  int         e_end  = 0;
  int         led_on_r0  = 0;
  int         led_off_r0 = 0;

  always #5 clock = ~clock;

  function automatic logic [3:0] rom_word(input int a);
    case (a)
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0100;
      3:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  assign mem_dado = rom_word(int'(mem_endereco));

  jogo_sequencia_rodadas #(
    .N_BOTOES(NB), .MAX_RODADAS(MR), .LED_CICLOS(LC), .TIMEOUT_CICLOS(TC)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .mem_dado(mem_dado), .mem_endereco(mem_endereco), .leds(leds),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_timeout(db_timeout),
    .db_rodada(db_rodada), .db_jogada(db_jogada), .db_estado(db_estado)
  );

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", nome, got, want, $time);
    end
  endtask

  // every cycle: DUT outputs against the scripted expectation
  always @(negedge clock) begin
    if (chk_on) begin
      chk("estado", 32'(db_estado), 32'(e_est));
      chk("leds", 32'(leds), 32'(e_leds));
      chk("pronto", 32'(pronto), 32'(e_est == 4'hA || e_est == 4'hE || e_est == 4'hD));
      chk("ganhou", 32'(ganhou), 32'(e_est == 4'hA));
      chk("perdeu", 32'(perdeu), 32'(e_est == 4'hE || e_est == 4'hD));
      chk("db_timeout", 32'(db_timeout), 32'(e_est == 4'hD));
      chk("rodada", 32'(db_rodada), 32'(e_rod));
      chk("endereco", 32'(mem_endereco), 32'(e_end));
      chk("jogada", 32'(db_jogada), 32'(e_jog));
      if (db_estado == 4'h2 && db_rodada == 2'd0 && leds == 4'b0001) led_on_r0++;
      if (db_estado == 4'h3 && db_rodada == 2'd0 && leds == 4'b0000) led_off_r0++;
    end
  end

  task automatic tick(input logic [3:0] est, input logic [3:0] lv, input int rod,
                      input int endr, input logic [3:0] jog);
    @(posedge clock);
    #1;
    e_est = est; e_leds = lv; e_rod = rod; e_end = endr; e_jog = jog;
  endtask

  task automatic rnd_jogar();
    jogar = 1'($urandom_range(0, 1));
  endtask

  // fr: failing round (MR = win); fi: failing press; fk: 0 wrong, 2 timeout,
  // 3 timeout with a held button; jmode: >=0 fixed delay, -1 short, -2 wide;
  // vfal: forced wrong value (0 = random); rst_r/rst_k: reset point in playback.
  task automatic jogo(input int fr, input int fi, input int fk, input int jmode,
                      input logic [3:0] vfal, input int rst_r, input int rst_k);
    int rod, j, k;
    logic [3:0] jog, val;
    bit fim, falha;
    jogar = 1'b1; botoes = '0;
    tick(4'h1, 4'h0, e_rod, e_end, e_jog);
    chk("prep_estado", 32'(db_estado), 32'h1);
    rod = 0; jog = 4'h0; fim = 1'b0;
    led_on_r0 = 0; led_off_r0 = 0;
    for (int r = 0; r < MR; r++) begin
      rod = r;
      for (int a = 0; a <= r && !fim; a++) begin
        for (int h = 0; h < 2 * LC && !fim; h++) begin
          k = a * 2 * LC + h;
          if (r == rst_r && k == rst_k) begin
            reset = 1'b0; jogar = 1'b0; botoes = '0;
            tick(4'h0, 4'h0, 0, 0, 4'h0);
            chk("midreset_estado", 32'(db_estado), 32'h0);
            chk("midreset_leds", 32'(leds), 32'h0);
            reset = 1'b1;
            fim = 1'b1;
          end else begin
            rnd_jogar();
            if (fk == 3 && r == fr && a == r) botoes = 4'b0001;
            else botoes = 4'($urandom_range(0, 15));
            tick((h < LC) ? 4'h2 : 4'h3, (h < LC) ? rom_word(a) : 4'h0, rod, a, jog);
            if (k == 0) begin
              chk("start_rodada", 32'(db_rodada), 32'(r));
              if (r == 0) chk("start_leds", 32'(leds), 32'b0001);
            end
          end
        end
      end
      if (fim) break;
      botoes = (fk == 3 && r == fr) ? 4'b0001 : 4'b0000;
      rnd_jogar();
      tick(4'h4, 4'h0, rod, 0, jog);
      for (int i = 0; i <= r; i++) begin
        falha = (r == fr && i == fi);
        if (falha && fk >= 2) begin
          for (int t = 1; t < TC; t++) begin
            rnd_jogar();
            tick(4'h4, 4'h0, rod, i, jog);
          end
          rnd_jogar();
          tick(4'hD, 4'h0, rod, i, jog);
          fim = 1'b1;
          break;
        end
        if (jmode >= 0)       j = jmode;
        else if (jmode == -1) j = $urandom_range(0, 4);
        else                  j = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TC - 1)
                                                              : $urandom_range(0, 4);
        for (int t = 0; t < j; t++) begin
          rnd_jogar(); botoes = '0;
          tick(4'h4, 4'h0, rod, i, jog);
        end
        if (!falha)          val = rom_word(i);
        else if (vfal != 0)  val = vfal;
        else if ($urandom_range(0, 1) == 0)
          val = rom_word((i + 1 + $urandom_range(0, 2)) % 4);
        else
          val = rom_word(i) | rom_word((i + 1 + $urandom_range(0, 2)) % 4);
        botoes = val; rnd_jogar();
        tick(4'h5, 4'h0, rod, i, jog);
        if (j == TC - 1) chk("press_at_timeout", 32'(db_estado), 32'h5);
        botoes = '0; jog = val; rnd_jogar();
        tick(4'h6, 4'h0, rod, i, jog);
        rnd_jogar();
        if (falha) begin
          tick(4'hE, 4'h0, rod, i, jog);
          fim = 1'b1;
          break;
        end
        if (i < r) begin
          tick(4'h4, 4'h0, rod, i + 1, jog);
        end else begin
          tick(4'h7, 4'h0, rod, i, jog);
          if (r == MR - 1) begin
            rnd_jogar();
            tick(4'hA, 4'h0, rod, i, jog);
            fim = 1'b1;
          end
        end
      end
      if (fim) break;
    end
    jogar = 1'b0;
    repeat (2) tick(e_est, e_leds, e_rod, e_end, e_jog);
  endtask

  initial begin
    int fr, fi, fk, rr;
    reset = 1'b0; jogar = 1'b0; botoes = '0;
    tick(4'h0, 4'h0, 0, 0, 4'h0);
    chk_on = 1'b1;
    jogar = 1'b1;
    tick(4'h0, 4'h0, 0, 0, 4'h0);
    reset = 1'b1; jogar = 1'b0;
    tick(4'h0, 4'h0, 0, 0, 4'h0);
    chk("reset_estado", 32'(db_estado), 32'h0);

    // full correct game, quick presses
    jogo(MR, 0, 0, -1, 4'h0, -1, -1);
    chk("win_estado", 32'(db_estado), 32'hA);
    chk("win_ganhou", 32'(ganhou), 32'h1);
    chk("win_pronto", 32'(pronto), 32'h1);
    chk("r0_led_on_cycles", 32'(led_on_r0), 32'd4);
    chk("r0_led_off_cycles", 32'(led_off_r0), 32'd4);

    // round 2, second press wrong (0100 instead of 0010)
    jogo(2, 1, 0, -1, 4'b0100, -1, -1);
    chk("wrong_estado", 32'(db_estado), 32'hE);
    chk("wrong_jogada", 32'(db_jogada), 32'b0100);
    chk("wrong_perdeu", 32'(perdeu), 32'h1);
    chk("wrong_timeout", 32'(db_timeout), 32'h0);

    // round 1, no press
    jogo(1, 0, 2, -1, 4'h0, -1, -1);
    chk("to_estado", 32'(db_estado), 32'hD);
    chk("to_flag", 32'(db_timeout), 32'h1);
    chk("to_perdeu", 32'(perdeu), 32'h1);

    // press on the exact timeout cycle, then a wrong press in round 1
    jogo(1, 0, 0, TC - 1, 4'h0, -1, -1);
    chk("late_estado", 32'(db_estado), 32'hE);

    // multi-button press in round 0
    jogo(0, 0, 0, -1, 4'b0011, -1, -1);
    chk("multi_estado", 32'(db_estado), 32'hE);
    chk("multi_jogada", 32'(db_jogada), 32'b0011);

    // button held into ESPERA never counts
    jogo(0, 0, 3, -1, 4'h0, -1, -1);
    chk("held_estado", 32'(db_estado), 32'hD);

    // reset in the middle of round 3 playback
    jogo(MR, 0, 0, -1, 4'h0, 3, $urandom_range(0, 2 * LC * MR - 1));
    chk("after_reset_estado", 32'(db_estado), 32'h0);

    // win, then restart straight from FIM_GANHOU
    jogo(MR, 0, 0, -2, 4'h0, -1, -1);
    chk("win2_estado", 32'(db_estado), 32'hA);

    for (int g = 0; g < 25; g++) begin
      fr = $urandom_range(0, MR);
      fi = (fr < MR) ? $urandom_range(0, fr) : 0;
      case ($urandom_range(0, 2))
        0:       fk = 0;
        1:       fk = 2;
        default: fk = 3;
      endcase
      if (fk == 3) fi = 0;
      rr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MR - 1) : -1;
      jogo(fr, fi, fk, -2, 4'h0, rr, $urandom_range(0, 2 * LC * (rr + 1) - 1));
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
